// File: rtl/text_stream_reader.sv
// ----------------------------------------------------------------------------
// text_stream_reader
//
// Reads a run of characters out of a text RAM and presents them one at a time
// on a valid/ready stream. After every LINE_LEN characters an EOL_CODE is
// inserted, except after the last character of a transfer. Every output is
// registered, so peak throughput is one character every two cycles.
//
// Ports
//   clk           : clock, rising edge
//   Reset         : asynchronous, active-high reset
//   start         : one-cycle request to begin a transfer (ignored while busy)
//   start_address : first RAM address to read
//   length        : number of RAM characters to stream (0 .. 2^ADDR_WIDTH)
//   abort         : synchronous cancel of a running transfer
//   read_address  : address to the text RAM read port
//   read_data     : combinational RAM data for read_address
//   char_data     : streamed character
//   char_valid    : char_data is valid
//   char_ready    : downstream accepts char_data
//   busy          : a transfer is in progress
//   done          : one-cycle pulse when a transfer completes
// ----------------------------------------------------------------------------
module text_stream_reader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    LINE_LEN   = 32,
    parameter logic [DATA_WIDTH-1:0] EOL_CODE   = 8'h5A
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] char_data,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int COL_W = $clog2(LINE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_EOL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] read_address_q, read_address_d;
    logic [DATA_WIDTH-1:0] char_data_q, char_data_d;
    logic                  char_valid_q, char_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  hs;
    logic                  last_char;
    logic                  line_end;
    logic                  go;
    logic [COL_W-1:0]      col_inc;

    assign hs        = char_valid_q && char_ready;
    assign last_char = (remaining_q == LEN_W'(1));
    assign col_inc   = col_q + COL_W'(1);
    assign line_end  = (col_inc == COL_W'(LINE_LEN));
    // A start coinciding with abort is treated as an abort.
    assign go        = start && !abort;

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = (length == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    // The final character never gets an EOL after it.
                    if (last_char) begin
                        state_d = S_DONE;
                    end else if (line_end) begin
                        state_d = S_EOL;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_EOL: begin
                if (hs) begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort wins over any handshake in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Output and datapath next-state logic
    always_comb begin
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        col_d        = col_q;
        char_data_d  = char_data_q;
        char_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go && (length != '0)) begin
                    addr_d      = start_address;
                    remaining_d = length;
                    col_d       = '0;
                end
            end
            S_LOAD: begin
                char_data_d  = read_data;
                char_valid_d = 1'b1;
            end
            S_SEND: begin
                if (hs) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    col_d       = col_inc;
                end else begin
                    char_valid_d = 1'b1;
                end
            end
            S_EOL: begin
                // First EOL cycle has valid low (the previous handshake just
                // happened); the code is presented from the following cycle.
                if (hs) begin
                    col_d = '0;
                end else begin
                    char_data_d  = EOL_CODE;
                    char_valid_d = 1'b1;
                end
            end
            default: begin
                char_valid_d = 1'b0;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            char_valid_d = 1'b0;
        end
        // The RAM address only moves when a LOAD is about to happen, so it
        // holds its last value through EOL, DONE and IDLE.
        read_address_d = (state_d == S_LOAD) ? addr_d : read_address_q;
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            addr_q         <= '0;
            remaining_q    <= '0;
            col_q          <= '0;
            read_address_q <= '0;
            char_data_q    <= '0;
            char_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            col_q          <= col_d;
            read_address_q <= read_address_d;
            char_data_q    <= char_data_d;
            char_valid_q   <= char_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign read_address = read_address_q;
    assign char_data    = char_data_q;
    assign char_valid   = char_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_text_stream_reader.sv
module tb_text_stream_reader;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int LL = 4;
  localparam logic [7:0] EOL = 8'h5A;

  logic          clk = 1'b0;
  logic          Reset;
  logic          start;
  logic          abort;
  logic          char_ready;
  logic [AW-1:0] start_address;
  logic [AW-1:0] read_address;
  logic [AW:0]   length;
  logic [DW-1:0] read_data;
  logic [DW-1:0] char_data;
  logic          char_valid;
  logic          busy;
  logic          done;

  logic [7:0] mem [0:511];
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_d[$];
  logic [7:0] got_d[$];
  logic [8:0] exp_a[$];
  logic [8:0] got_a[$];

  always #5 clk = ~clk;

  assign read_data = mem[read_address];

  text_stream_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LINE_LEN  (LL),
    .EOL_CODE  (EOL)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .start        (start),
    .start_address(start_address),
    .length       (length),
    .abort        (abort),
    .read_address (read_address),
    .read_data    (read_data),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transfer. stall_idx >= 0 holds char_ready low for 5 cycles when
  // that symbol appears; restart_at > 0 fires a second start at that cycle.
  task automatic run_transfer(input string name, input logic [8:0] sa, input logic [9:0] len,
                              input int stall_idx, input int restart_at,
                              output int nsyms, output logic [7:0] first, output logic [7:0] last,
                              output logic [8:0] last_addr_idle);
    logic [8:0] a;
    logic [7:0] hold;
    bit done_seen, busy_ok, dv_ok, stable_ok;
    int stall_cnt, sym;
    exp_d.delete(); exp_a.delete(); got_d.delete(); got_a.delete();
    for (int i = 0; i < int'(len); i++) begin
      a = sa + 9'(i);
      exp_d.push_back(mem[a]);
      exp_a.push_back(a);
      if (((i + 1) % LL) == 0 && i != int'(len) - 1) begin
        exp_d.push_back(EOL);
        exp_a.push_back(a);
      end
    end
    done_seen = 0; busy_ok = 1; dv_ok = 1; stable_ok = 1; stall_cnt = 0; sym = 0; hold = '0;
    @(negedge clk);
    start_address = sa; length = len; start = 1'b1;
    for (int c = 1; c <= 3000 && !done_seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == restart_at) begin
        start = 1'b1; start_address = 9'h100; length = 10'd9;
      end
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) begin
        done_seen = 1;
        if (char_valid !== 1'b0) dv_ok = 0;
      end
      char_ready = 1'b1;
      if (sym == stall_idx && stall_cnt > 0 && stall_cnt < 5) begin
        if (char_valid !== 1'b1 || char_data !== hold) stable_ok = 0;
        char_ready = 1'b0;
        stall_cnt++;
      end else if (sym == stall_idx && stall_cnt == 0 && char_valid === 1'b1) begin
        hold = char_data;
        char_ready = 1'b0;
        stall_cnt = 1;
      end
      if (char_valid === 1'b1 && char_ready) begin
        got_d.push_back(char_data);
        got_a.push_back(read_address);
        sym++;
      end
    end
    start = 1'b0;
    check({name, " done seen"}, 32'(done_seen), 32'd1);
    check({name, " busy held"}, 32'(busy_ok), 32'd1);
    check({name, " valid low in done"}, 32'(dv_ok), 32'd1);
    check({name, " symbol count"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      check($sformatf("%s sym%0d data", name, k), 32'(got_d[k]), 32'(exp_d[k]));
      check($sformatf("%s sym%0d addr", name, k), 32'(got_a[k]), 32'(exp_a[k]));
    end
    if (stall_idx >= 0) begin
      check({name, " stall stable"}, 32'(stable_ok), 32'd1);
      check({name, " stall length"}, 32'(stall_cnt), 32'd5);
    end
    @(negedge clk);
    check({name, " done single pulse"}, 32'(done), 32'd0);
    check({name, " busy cleared"}, 32'(busy), 32'd0);
    nsyms = got_d.size();
    first = (got_d.size() > 0) ? got_d[0] : 8'h00;
    last = (got_d.size() > 0) ? got_d[got_d.size() - 1] : 8'h00;
    last_addr_idle = read_address;
  endtask

  typedef struct {
    logic [8:0] sa;
    logic [9:0] len;
    int         syms;
    logic [7:0] first;
    logic [7:0] last;
    logic [8:0] laddr;
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    int ns, hcnt;
    logic [7:0] f, l;
    logic [8:0] la;
    bit seen, bad;

    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    mem[9'h010] = 8'h41; mem[9'h011] = 8'h42; mem[9'h012] = 8'h43;

    //          sa      len     syms first  last   idle addr
    vecs[0] = '{9'h010, 10'd3,   3,  8'h41, 8'h43, 9'h012};
    vecs[1] = '{9'h000, 10'd9,   11, 8'h00, 8'h08, 9'h008};
    vecs[2] = '{9'h1FE, 10'd4,   4,  8'hFE, 8'h01, 9'h001};
    vecs[3] = '{9'h100, 10'd5,   6,  8'h00, 8'h04, 9'h104};
    vecs[4] = '{9'h020, 10'd1,   1,  8'h20, 8'h20, 9'h020};
    vecs[5] = '{9'h033, 10'd0,   0,  8'h00, 8'h00, 9'h020};
    vecs[6] = '{9'h0F0, 10'd8,   9,  8'hF0, 8'hF7, 9'h0F7};
    vecs[7] = '{9'h005, 10'd512, 639, 8'h05, 8'h04, 9'h004};

    Reset = 1'b1; start = 1'b0; abort = 1'b0; char_ready = 1'b1;
    start_address = '0; length = '0;
    repeat (2) @(negedge clk);
    check("reset read_address", 32'(read_address), 32'h0);
    check("reset char_data", 32'(char_data), 32'h0);
    check("reset char_valid", 32'(char_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    Reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_transfer($sformatf("vec%0d", v), vecs[v].sa, vecs[v].len, -1, -1, ns, f, l, la);
      check($sformatf("vec%0d hand count", v), 32'(ns), 32'(vecs[v].syms));
      if (vecs[v].syms > 0) begin
        check($sformatf("vec%0d first", v), 32'(f), 32'(vecs[v].first));
        check($sformatf("vec%0d last", v), 32'(l), 32'(vecs[v].last));
      end
      check($sformatf("vec%0d idle read_address", v), 32'(la), 32'(vecs[v].laddr));
    end

    // Backpressure on the second character.
    run_transfer("stall", 9'h010, 10'd3, 1, -1, ns, f, l, la);
    check("stall last", 32'(l), 32'h43);

    // Second start while busy must be ignored.
    run_transfer("restart", 9'h010, 10'd3, -1, 3, ns, f, l, la);
    check("restart count", 32'(ns), 32'd3);

    // Abort in SEND together with a handshake.
    @(negedge clk);
    start_address = 9'h040; length = 10'd5; start = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      char_ready = 1'b1;
      if (char_valid === 1'b1) seen = 1;
    end
    check("abort reached SEND", 32'(seen), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort char_valid", 32'(char_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || char_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    check("abort stays idle", 32'(bad), 32'd0);

    // Start and abort together in IDLE.
    start_address = 9'h050; length = 10'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    bad = 0;
    repeat (4) begin
      if (busy !== 1'b0 || char_valid !== 1'b0 || done !== 1'b0) bad = 1;
      @(negedge clk);
    end
    check("start+abort idle", 32'(bad), 32'd0);

    // Reset during the third character of a 10-character transfer.
    start_address = 9'h080; length = 10'd10; start = 1'b1;
    hcnt = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      char_ready = 1'b1;
      if (char_valid === 1'b1) begin
        if (hcnt == 2) seen = 1;
        else hcnt++;
      end
    end
    check("third char reached", 32'(seen), 32'd1);
    check("third char value", 32'(char_data), 32'h82);
    Reset = 1'b1;
    #1;
    check("midreset read_address", 32'(read_address), 32'h0);
    check("midreset char_data", 32'(char_data), 32'h0);
    check("midreset char_valid", 32'(char_valid), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    check("midreset done", 32'(done), 32'h0);
    @(negedge clk);
    Reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || char_valid !== 1'b0 || done !== 1'b0) bad = 1;
    end
    check("post-reset idle", 32'(bad), 32'd0);
    run_transfer("after reset", 9'h0A0, 10'd6, -1, -1, ns, f, l, la);
    check("after reset count", 32'(ns), 32'd7);
    check("after reset first", 32'(f), 32'hA0);
    check("after reset last", 32'(l), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
